tff_updown_counter: RTL

//   Modulo-N synchronous up/down counter. Every state bit is a T flip-flop:
//   Q <= Q ^ T. Per-bit toggle enables are computed as T = count ^ next_count.

---
 rtl/tff_updown_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - modulo-N up/down counter built from T flip-flops (optional TFF_CROSSCHECK_EN shadow banks)

// One T flip-flop cell: the stored bit only ever changes by toggling.
module tff_bit (
  input  logic clk,
  input  logic reset,
  input  logic t_i,
  output logic q_o
);

  logic q_q;

  // Toggle on T, clear on synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_q ^ t_i;
    end
  end

  assign q_o = q_q;

endmodule

// Counter top: next-state logic produces a target value, the toggle vector
// is the XOR of current and target, and the T bank applies it.
module tff_updown_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] t_vec_o,
  output logic             tc_o,
  output logic             load_err_o
`ifdef TFF_CROSSCHECK_EN
  ,
  output logic             mismatch_o
`endif
);

  // MODULO may equal 2**WIDTH, so range checks use one extra bit.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] t_vec;
  logic             at_max;
  logic             at_zero;
  logic             load_oor;
  logic             load_err_q;
  logic             load_err_d;

  assign at_max   = (count_q == MAX_CNT);
  assign at_zero  = (count_q == '0);
  assign load_oor = ({1'b0, load_val_i} >= MOD_EXT);

  // Target value for the next edge: reset > load > en, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_oor ? MAX_CNT : load_val_i;
    end else if (en_i) begin
      if (up_dn_i) begin
        count_d = at_max ? '0 : (count_q + ONE);
      end else begin
        count_d = at_zero ? MAX_CNT : (count_q - ONE);
      end
    end
  end

  // Only bits that must change get toggled; a hold yields an all-zero vector.
  assign t_vec = count_q ^ count_d;

  // The state bank: one T flip-flop per count bit, no direct D path.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tff
      tff_bit u_tff (
        .clk   (clk),
        .reset (reset),
        .t_i   (t_vec[gi]),
        .q_o   (count_q[gi])
      );
    end
  endgenerate

  // An out-of-range load is flagged for exactly the cycle after the strobe.
  assign load_err_d = load_i & load_oor;

  // Registered load error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign t_vec_o    = t_vec;
  assign load_err_o = load_err_q;
  assign tc_o       = en_i & ~load_i & ~reset & (up_dn_i ? at_max : at_zero);

`ifdef TFF_CROSSCHECK_EN
  logic [WIDTH-1:0] jk_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_s;
  logic [WIDTH-1:0] sr_r;
  logic             mismatch_q;

  // Set/reset terms derived from the SR bank's own state so it tracks independently.
  assign sr_s = t_vec & ~sr_q;
  assign sr_r = t_vec & sr_q;

  // Shadow JK bank with J=K=T: (J & ~Q) | (~K & Q).
  always_ff @(posedge clk) begin
    if (reset) begin
      jk_q <= '0;
    end else begin
      jk_q <= (t_vec & ~jk_q) | (~t_vec & jk_q);
    end
  end

  // Shadow SR bank: S | (~R & Q); S and R are never both set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_s | (~sr_r & sr_q);
    end
  end

  // Sticky disagreement flag between the shadow banks and the T bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_q | (jk_q != count_q) | (sr_q != count_q);
    end
  end

  assign mismatch_o = mismatch_q;
`endif

endmodule
